// File: rtl/xbus_vec_fifo_bank_if.sv
// Signal bundle for the xbus vector FIFO bank. The producer/consumer side drives
// the requests and the FIFO bank drives the status and data.
// A transfer on channel i occurs on a clk edge where the request (wr_en[i]/rd_en[i]) is
// high and the bank can take it: a write needs ~full[i] or a same-cycle accepted pop,
// and a read needs ~empty[i] (all_valid in lockstep). Refused requests leave the data
// unchanged and raise ovf/udf.
interface xbus_vec_fifo_bank_if #(
  parameter int P     = 16,
  parameter int DW    = 64,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            lockstep;
  logic            err_clr;
  logic [P-1:0]    wr_en;
  logic [P*DW-1:0] din;
  logic [P-1:0]    full;
  logic [P-1:0]    prog_full;
  logic [P-1:0]    rd_en;
  logic [P*DW-1:0] dout;
  logic [P-1:0]    empty;
  logic            all_valid;
  logic [P*CW-1:0] count;
  logic [P-1:0]    ovf;
  logic [P-1:0]    udf;

  modport master (
    output flush, lockstep, err_clr, wr_en, din, rd_en,
    input  full, prog_full, dout, empty, all_valid, count, ovf, udf
  );

  modport slave (
    input  flush, lockstep, err_clr, wr_en, din, rd_en,
    output full, prog_full, dout, empty, all_valid, count, ovf, udf
  );
endinterface

// File: rtl/xbus_vec_fifo_bank.sv
// Bank of P independent first-word-fall-through vector FIFOs with occupancy counts,
// lockstep multi-channel pop, synchronous flush and sticky overflow/underflow flags.
module xbus_vec_fifo_bank #(
   parameter int P         = 16,
   parameter int DW        = 64,
   parameter int DEPTH     = 64,
   parameter int PROG_FULL = 54,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input logic                clk,
   input logic                rst,
   xbus_vec_fifo_bank_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [P-1:0] empty;
   logic [P-1:0] full;
   logic [P-1:0] rd_req;
   logic [P-1:0] rd_acc;
   logic [P-1:0] wr_acc;
   logic [P-1:0] ovf_set;
   logic [P-1:0] udf_set;
   logic         all_valid;

   assign all_valid     = &(~empty);
   assign bus.all_valid = all_valid;
   assign bus.empty     = empty;
   assign bus.full      = full;

   // A refused pop only counts as underflow on an empty channel, so lockstep pops
   // blocked by some other empty channel do not flag the non-empty ones.
   always_comb begin
      rd_req  = bus.lockstep ? {P{bus.rd_en[0]}} : bus.rd_en;
      rd_acc  = '0;
      wr_acc  = '0;
      ovf_set = '0;
      udf_set = '0;
      if (!bus.flush) begin
         if (bus.lockstep) rd_acc = {P{bus.rd_en[0] & all_valid}};
         else              rd_acc = bus.rd_en & ~empty;
         wr_acc  = bus.wr_en & (~full | rd_acc);
         ovf_set = bus.wr_en & ~wr_acc;
         udf_set = rd_req & empty;
      end
   end

   for (genvar i = 0; i < P; i++) begin : g_ch
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wptr;
      logic [AW-1:0] rptr;
      logic [CW-1:0] cnt;
      logic          ovf_q;
      logic          udf_q;

      assign empty[i]                = (cnt == '0);
      assign full[i]                 = (cnt == CW'(DEPTH));
      assign bus.prog_full[i]        = (cnt >= CW'(PROG_FULL));
      assign bus.count[i*CW +: CW]   = cnt;
      assign bus.dout[i*DW +: DW]    = mem[rptr];
      assign bus.ovf[i]              = ovf_q;
      assign bus.udf[i]              = udf_q;

      // Storage has no reset; contents are only visible through counted entries.
      always_ff @(posedge clk) begin
         if (wr_acc[i]) mem[wptr] <= bus.din[i*DW +: DW];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (wr_acc[i]) wptr <= wptr + AW'(1);
            if (rd_acc[i]) rptr <= rptr + AW'(1);
            case ({wr_acc[i], rd_acc[i]})
               2'b10:   cnt <= cnt + CW'(1);
               2'b01:   cnt <= cnt - CW'(1);
               default: cnt <= cnt;
            endcase
         end
      end

      // Set beats clear when both happen in the same cycle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            ovf_q <= ovf_set[i] | (ovf_q & ~bus.err_clr);
            udf_q <= udf_set[i] | (udf_q & ~bus.err_clr);
         end
      end
   end
endmodule

// File: tb/tb_xbus_vec_fifo_bank.sv
// Directed self-checking bench for xbus_vec_fifo_bank: threshold, full/overflow,
// lockstep, pointer wrap, flush/error clearing and asynchronous reset scenarios.
module tb_xbus_vec_fifo_bank;
   localparam int P         = 16;
   localparam int DW        = 64;
   localparam int DEPTH     = 64;
   localparam int PROG_FULL = 54;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [DW-1:0] exp_q[$];

   xbus_vec_fifo_bank_if #(.P(P), .DW(DW), .DEPTH(DEPTH)) bus ();

   xbus_vec_fifo_bank #(.P(P), .DW(DW), .DEPTH(DEPTH), .PROG_FULL(PROG_FULL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] cnt_of(int ch);
      return bus.count[ch*CW +: CW];
   endfunction

   function automatic logic [DW-1:0] dout_of(int ch);
      return bus.dout[ch*DW +: DW];
   endfunction

   task automatic set_din(int ch, logic [DW-1:0] v);
      bus.din[ch*DW +: DW] = v;
   endtask

   task automatic test_reset();
      bus.flush = 0; bus.lockstep = 0; bus.err_clr = 0;
      bus.wr_en = '0; bus.rd_en = '0; bus.din = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++; if (bus.count !== '0) $display("FAIL reset_count got %h exp 0", bus.count); else n_pass++;
      n_checks++; if (bus.empty !== 16'hFFFF) $display("FAIL reset_empty got %h exp ffff", bus.empty); else n_pass++;
      n_checks++; if (bus.full !== '0) $display("FAIL reset_full got %h exp 0", bus.full); else n_pass++;
      n_checks++; if (bus.prog_full !== '0) $display("FAIL reset_prog_full got %h exp 0", bus.prog_full); else n_pass++;
      n_checks++; if (bus.all_valid !== 1'b0) $display("FAIL reset_all_valid got %b exp 0", bus.all_valid); else n_pass++;
      n_checks++; if ({bus.ovf, bus.udf} !== '0) $display("FAIL reset_flags got %h/%h exp 0", bus.ovf, bus.udf); else n_pass++;
   endtask

   task automatic test_prog_full();
      for (int k = 0; k < 54; k++) begin
         bus.wr_en = 16'h0001; set_din(0, 64'h11 + 64'(k));
         step();
         bus.wr_en = '0;
         if (k == 47) begin
            n_checks++; if (cnt_of(0) !== 7'd48) $display("FAIL pf_count48 got %0d exp 48", cnt_of(0)); else n_pass++;
            n_checks++; if (bus.prog_full[0] !== 1'b0) $display("FAIL pf_at48 got %b exp 0", bus.prog_full[0]); else n_pass++;
         end
         if (k == 52) begin
            n_checks++; if (bus.prog_full[0] !== 1'b0) $display("FAIL pf_at53 got %b exp 0", bus.prog_full[0]); else n_pass++;
         end
      end
      n_checks++; if (cnt_of(0) !== 7'd54) $display("FAIL pf_count54 got %0d exp 54", cnt_of(0)); else n_pass++;
      n_checks++; if (bus.prog_full[0] !== 1'b1) $display("FAIL pf_at54 got %b exp 1", bus.prog_full[0]); else n_pass++;
      for (int k = 0; k < 54; k++) begin
         n_checks++;
         if (dout_of(0) !== 64'h11 + 64'(k)) $display("FAIL pf_read%0d got %h exp %h", k, dout_of(0), 64'h11 + 64'(k));
         else n_pass++;
         bus.rd_en = 16'h0001;
         step();
         bus.rd_en = '0;
      end
      n_checks++; if (bus.empty[0] !== 1'b1) $display("FAIL pf_empty got %b exp 1", bus.empty[0]); else n_pass++;
   endtask

   task automatic test_full_ovf();
      for (int k = 0; k < 64; k++) begin
         bus.wr_en = 16'h0002; set_din(1, 64'h100 + 64'(k));
         step();
      end
      bus.wr_en = '0;
      n_checks++; if (bus.full[1] !== 1'b1) $display("FAIL full_flag got %b exp 1", bus.full[1]); else n_pass++;
      bus.wr_en = 16'h0002; set_din(1, 64'hDEAD);
      step();
      bus.wr_en = '0;
      n_checks++; if (bus.ovf !== 16'h0002) $display("FAIL full_ovf got %h exp 0002", bus.ovf); else n_pass++;
      n_checks++; if (cnt_of(1) !== 7'd64) $display("FAIL full_count got %0d exp 64", cnt_of(1)); else n_pass++;
      n_checks++; if (dout_of(1) !== 64'h100) $display("FAIL full_head got %h exp 100", dout_of(1)); else n_pass++;
      bus.wr_en = 16'h0002; bus.rd_en = 16'h0002; set_din(1, 64'hBEEF);
      step();
      bus.wr_en = '0; bus.rd_en = '0;
      n_checks++; if (cnt_of(1) !== 7'd64) $display("FAIL full_simul_count got %0d exp 64", cnt_of(1)); else n_pass++;
      for (int k = 1; k < 64; k++) begin
         n_checks++;
         if (dout_of(1) !== 64'h100 + 64'(k)) $display("FAIL full_read%0d got %h exp %h", k, dout_of(1), 64'h100 + 64'(k));
         else n_pass++;
         bus.rd_en = 16'h0002;
         step();
         bus.rd_en = '0;
      end
      n_checks++; if (dout_of(1) !== 64'hBEEF) $display("FAIL full_new_word got %h exp beef", dout_of(1)); else n_pass++;
      bus.rd_en = 16'h0002;
      step();
      bus.rd_en = '0; bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      n_checks++; if (bus.empty[1] !== 1'b1) $display("FAIL full_drained got %b exp 1", bus.empty[1]); else n_pass++;
      n_checks++; if (bus.ovf !== '0) $display("FAIL full_err_clr got %h exp 0", bus.ovf); else n_pass++;
   endtask

   task automatic test_lockstep();
      bus.lockstep = 1'b1;
      bus.wr_en = 16'h7FFF;
      for (int i = 0; i < P; i++) set_din(i, 64'h200 + 64'(i));
      step();
      bus.wr_en = '0; bus.rd_en = 16'h0001;
      step();
      bus.rd_en = '0;
      for (int i = 0; i < 15; i++) begin
         n_checks++; if (cnt_of(i) !== 7'd1) $display("FAIL ls_blocked_ch%0d got %0d exp 1", i, cnt_of(i)); else n_pass++;
      end
      n_checks++; if (bus.udf !== 16'h8000) $display("FAIL ls_udf got %h exp 8000", bus.udf); else n_pass++;
      bus.wr_en = 16'h8000;
      step();
      bus.wr_en = '0;
      n_checks++; if (bus.all_valid !== 1'b1) $display("FAIL ls_all_valid got %b exp 1", bus.all_valid); else n_pass++;
      bus.rd_en = 16'hFFFE;
      step();
      bus.rd_en = '0;
      n_checks++; if (bus.empty !== '0) $display("FAIL ls_upper_ignored got %h exp 0", bus.empty); else n_pass++;
      for (int i = 0; i < P; i++) begin
         n_checks++; if (dout_of(i) !== 64'h200 + 64'(i)) $display("FAIL ls_dout_ch%0d got %h exp %h", i, dout_of(i), 64'h200 + 64'(i)); else n_pass++;
      end
      bus.rd_en = 16'h0001;
      step();
      bus.rd_en = '0;
      n_checks++; if (bus.empty !== 16'hFFFF) $display("FAIL ls_pop_all got %h exp ffff", bus.empty); else n_pass++;
      bus.err_clr = 1'b1; bus.lockstep = 1'b0;
      step();
      bus.err_clr = 1'b0;
      n_checks++; if (bus.udf !== '0) $display("FAIL ls_udf_clr got %h exp 0", bus.udf); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] v;
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         v = 64'h3000 + 64'(k);
         bus.wr_en = 16'h0004; set_din(2, v); exp_q.push_back(v);
         step();
      end
      for (int k = 3; k < 200; k++) begin
         v = 64'h3000 + 64'(k);
         n_checks++;
         if (dout_of(2) !== exp_q[0]) $display("FAIL wrap_data%0d got %h exp %h", k - 3, dout_of(2), exp_q[0]);
         else n_pass++;
         void'(exp_q.pop_front());
         bus.wr_en = 16'h0004; bus.rd_en = 16'h0004; set_din(2, v); exp_q.push_back(v);
         step();
         n_checks++; if (cnt_of(2) !== 7'd3) $display("FAIL wrap_count%0d got %0d exp 3", k, cnt_of(2)); else n_pass++;
      end
      bus.wr_en = '0;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (dout_of(2) !== exp_q[0]) $display("FAIL wrap_drain got %h exp %h", dout_of(2), exp_q[0]);
         else n_pass++;
         void'(exp_q.pop_front());
         bus.rd_en = 16'h0004;
         step();
      end
      bus.rd_en = '0;
      n_checks++; if (bus.empty[2] !== 1'b1) $display("FAIL wrap_empty got %b exp 1", bus.empty[2]); else n_pass++;
   endtask

   task automatic test_flush_err();
      bus.wr_en = '1;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < P; i++) set_din(i, 64'($urandom_range(0, 65535)));
         step();
      end
      bus.wr_en = '0;
      for (int i = 0; i < P; i++) begin
         n_checks++; if (cnt_of(i) !== 7'd10) $display("FAIL fl_pre_ch%0d got %0d exp 10", i, cnt_of(i)); else n_pass++;
      end
      bus.flush = 1'b1; bus.wr_en = '1; bus.rd_en = '1;
      step();
      bus.flush = 1'b0; bus.wr_en = '0; bus.rd_en = '0;
      n_checks++; if (bus.count !== '0) $display("FAIL fl_count got %h exp 0", bus.count); else n_pass++;
      n_checks++; if (bus.empty !== 16'hFFFF) $display("FAIL fl_empty got %h exp ffff", bus.empty); else n_pass++;
      n_checks++; if ({bus.ovf, bus.udf} !== '0) $display("FAIL fl_flags got %h/%h exp 0", bus.ovf, bus.udf); else n_pass++;
      bus.wr_en = 16'h0008;
      for (int k = 0; k < 65; k++) step();
      bus.wr_en = '0;
      n_checks++; if (bus.ovf !== 16'h0008) $display("FAIL fl_ovf_set got %h exp 0008", bus.ovf); else n_pass++;
      bus.wr_en = 16'h0008; bus.err_clr = 1'b1;
      step();
      bus.wr_en = '0; bus.err_clr = 1'b0;
      n_checks++; if (bus.ovf[3] !== 1'b1) $display("FAIL fl_set_wins got %b exp 1", bus.ovf[3]); else n_pass++;
      bus.err_clr = 1'b1; bus.flush = 1'b1;
      step();
      bus.err_clr = 1'b0; bus.flush = 1'b0;
      n_checks++; if (bus.ovf !== '0) $display("FAIL fl_clr got %h exp 0", bus.ovf); else n_pass++;
      n_checks++; if (cnt_of(3) !== 7'd0) $display("FAIL fl_ch3_flush got %0d exp 0", cnt_of(3)); else n_pass++;
   endtask

   task automatic test_async_reset();
      bus.wr_en = '1;
      for (int k = 0; k < 20; k++) step();
      n_checks++; if (cnt_of(0) !== 7'd20) $display("FAIL ar_pre got %0d exp 20", cnt_of(0)); else n_pass++;
      bus.rd_en = '1;
      #1 rst = 1'b1;
      #1;
      n_checks++; if (bus.count !== '0) $display("FAIL ar_count got %h exp 0", bus.count); else n_pass++;
      n_checks++; if (bus.empty !== 16'hFFFF) $display("FAIL ar_empty got %h exp ffff", bus.empty); else n_pass++;
      step();
      rst = 1'b0; bus.rd_en = '0; bus.wr_en = 16'h0001; set_din(0, 64'hCAFE);
      step();
      bus.wr_en = '0;
      n_checks++; if (cnt_of(0) !== 7'd1) $display("FAIL ar_resume_count got %0d exp 1", cnt_of(0)); else n_pass++;
      n_checks++; if (dout_of(0) !== 64'hCAFE) $display("FAIL ar_resume_dout got %h exp cafe", dout_of(0)); else n_pass++;
      n_checks++; if (bus.empty !== 16'hFFFE) $display("FAIL ar_resume_empty got %h exp fffe", bus.empty); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_prog_full();
      test_full_ovf();
      test_lockstep();
      test_back_to_back();
      test_flush_err();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/xbus_vec_fifo_bank.md
Name: xbus_vec_fifo_bank

Overview:
- Parametrised bank of P independent per-channel vector FIFOs on the xbus datapath, sitting between the vector producers and the PE-array consumers.
- Adds features the fixed bank lacks:
  - configurable width, depth and threshold
  - first-word-fall-through (FWFT) reads
  - per-channel occupancy counts
  - lockstep read mode that pops all channels together
  - synchronous flush
  - sticky overflow/underflow error flags

Parameters:
P, 16, number of channels
DW, 64, data width per channel in bits
DEPTH, 64, entries per channel; power of two, at least 4
PROG_FULL, 54, prog_full asserts when count >= PROG_FULL; range 1..DEPTH
CW, $clog2(DEPTH)+1, count width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of all channels
lockstep  in  1  0 = independent reads; 1 = rd_en[0] pops all channels
err_clr  in  1  clears sticky ovf/udf flags
wr_en  in  P  per-channel write request
din  in  P*DW  channel i data at din[i*DW +: DW]
full  out  P  channel holds DEPTH entries
prog_full  out  P  count >= PROG_FULL
rd_en  in  P  per-channel pop request
dout  out  P*DW  head entry of channel i (FWFT)
empty  out  P  channel holds 0 entries
all_valid  out  1  AND of ~empty over all channels
count  out  P*CW  occupancy of channel i at count[i*CW +: CW]
ovf  out  P  sticky: write request refused
udf  out  P  sticky: read request refused

Behaviour:
Storage and reset
- Clock domain: single clock, clk.
- Reset: asynchronous active-high. While rst = 1 and after release:
  - pointers = 0, count = 0
  - empty = all 1, full = 0, prog_full = 0, all_valid = 0
  - ovf = 0, udf = 0
- Storage: distributed RAM with asynchronous read. Each channel has a write pointer, read pointer and count register. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- dout[i] = mem_i[rptr_i] combinationally. dout is don't-care while empty[i] = 1.
- Flag derivation: empty, full, prog_full and all_valid come combinationally from the registered count. They change the cycle after the causing transfer; there is no look-ahead.

Accept rules, per channel i, evaluated each cycle
- rd_req[i]:
  - lockstep = 0: rd_req[i] = rd_en[i]
  - lockstep = 1: rd_req[i] = rd_en[0] for every i; rd_en[P-1:1] are ignored.
- rd_acc[i]:
  - lockstep = 0: rd_acc[i] = rd_req[i] & ~empty[i]
  - lockstep = 1: rd_acc[i] = rd_en[0] & all_valid. Either all channels pop or none do.
- wr_acc[i] = wr_en[i] & (~full[i] | rd_acc[i]). A write to a full channel is accepted when a read on that channel is accepted in the same cycle.
- A write to an empty channel is not readable until the next cycle.

Update and flags
- Count update: count += wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged; both pointers advance.
- ovf[i] sets on wr_en[i] & ~wr_acc[i].
- udf[i] sets on rd_req[i] & ~rd_acc[i].
  - In lockstep, a refused rd_en[0] sets udf only on channels that are empty. Non-empty channels that were blocked do not set udf.
- err_clr clears all flags. When a set condition and err_clr occur in the same cycle, the set wins.
- Flush:
  - Flush = 1 zeroes pointers and counts on the next edge and suppresses all reads and writes that cycle.
  - Writes during flush are dropped without setting ovf; reads during flush do not set udf.
  - Flush leaves ovf/udf unchanged.
- Mode switch: lockstep may change on any cycle and takes effect the same cycle; no data is lost.
- Reset mid-operation: all contents are discarded immediately; state is as after reset.

Test Plan:
1. Reset, then write 0x11..0x40 (48 words) to ch0 -> count[0] = 48, prog_full[0] = 0. Write 6 more -> count = 54 and prog_full[0] = 1 the cycle after the 54th write. Read all back in order, dout equals the written sequence, empty[0] = 1 at the end.
2. Fill ch1 to 64 -> full[1] = 1. Write with no read -> ovf[1] = 1, count stays 64. Write and read in the same cycle -> both accepted, count stays 64, and the new word appears after 63 further pops.
3. lockstep = 1, ch0..ch14 hold 1 word each, ch15 empty, rd_en[0] = 1 -> no channel pops, udf[15] = 1, udf[14:0] = 0. Write ch15 -> all_valid = 1 next cycle; rd_en[0] pulse pops all 16, all empty next cycle.
4. Pointer wrap: stream 200 words through ch2 with simultaneous read and write at occupancy 3 -> all 200 words are returned in order, count stays 3.
5. flush with wr_en = all 1 and rd_en = all 1 at counts of 10 -> next cycle all counts are 0, empty = all 1, ovf = udf = 0. Then assert err_clr together with a new ovf event -> ovf remains 1.
6. Assert rst asynchronously mid-stream with counts of 20 -> count = 0 and empty = 1 without waiting for a clk edge. Normal operation resumes on the first edge after release.
